// File: rtl/gbm_path_sequencer.sv
// Sequences Monte-Carlo paths through one GBM step lane, keeping each path's spot
// price locally and allowing at most one outstanding step per path.
module gbm_path_sequencer #(
    parameter int WIDTH     = 32,
    parameter int QFRAC     = 16,
    parameter int NUM_PATHS = 8,
    parameter int NUM_STEPS = 16,
    parameter int PW        = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1,
    parameter int SW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] S0,
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] sigma_in,
    input  logic [WIDTH-1:0] dt_in,
    output logic             busy,
    output logic             done,
    input  logic             z_valid,
    output logic             z_ready,
    input  logic [WIDTH-1:0] z,
    output logic             gbm_valid,
    input  logic             gbm_ready,
    output logic [WIDTH-1:0] gbm_z,
    output logic [WIDTH-1:0] gbm_S,
    output logic [WIDTH-1:0] gbm_r,
    output logic [WIDTH-1:0] gbm_sigma,
    output logic [WIDTH-1:0] gbm_dt,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [WIDTH-1:0] res_S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_S,
    output logic [PW-1:0]    out_path,
    output logic [SW-1:0]    out_step,
    output logic             out_last
);

    if (QFRAC < 0 || QFRAC >= WIDTH) begin : g_bad_qfrac
        $error("QFRAC must lie within the word width");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    localparam logic [PW-1:0] LAST_PATH = PW'(NUM_PATHS - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

    state_t                 state_q, state_d;
    logic [PW-1:0]          issue_path_q, issue_path_d;
    logic [SW-1:0]          issue_step_q, issue_step_d;
    logic [PW-1:0]          ret_path_q, ret_path_d;
    logic [SW-1:0]          ret_step_q, ret_step_d;
    logic [NUM_PATHS-1:0]   pending_q, pending_d;
    logic [WIDTH-1:0]       r_q, r_d;
    logic [WIDTH-1:0]       sigma_q, sigma_d;
    logic [WIDTH-1:0]       dt_q, dt_d;
    logic [WIDTH-1:0]       s_file_q [NUM_PATHS];
    logic [WIDTH-1:0]       s_file_d [NUM_PATHS];

    logic issue_ok, ret_ok, issue_fire, res_fire;
    logic issue_is_last, ret_is_last;

    // Pending is read from the register, so a path returning this cycle issues next cycle.
    assign issue_ok      = (state_q == ST_ISSUE) && !pending_q[issue_path_q];
    assign ret_ok        = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && (|pending_q);
    assign issue_fire    = issue_ok && z_valid && gbm_ready;
    assign res_fire      = ret_ok && res_valid && out_ready;
    assign issue_is_last = (issue_path_q == LAST_PATH) && (issue_step_q == LAST_STEP);
    assign ret_is_last   = (ret_path_q == LAST_PATH) && (ret_step_q == LAST_STEP);

    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign gbm_valid = issue_ok && z_valid;
    assign z_ready   = issue_ok && gbm_ready;
    assign gbm_z     = z;
    assign gbm_S     = s_file_q[issue_path_q];
    assign gbm_r     = r_q;
    assign gbm_sigma = sigma_q;
    assign gbm_dt    = dt_q;
    assign res_ready = ret_ok && out_ready;
    assign out_valid = ret_ok && res_valid;
    assign out_S     = res_S;
    assign out_path  = ret_path_q;
    assign out_step  = ret_step_q;
    assign out_last  = out_valid && ret_is_last;

    always_comb begin
        state_d      = state_q;
        issue_path_d = issue_path_q;
        issue_step_d = issue_step_q;
        ret_path_d   = ret_path_q;
        ret_step_d   = ret_step_q;
        pending_d    = pending_q;
        r_d          = r_q;
        sigma_d      = sigma_q;
        dt_d         = dt_q;
        s_file_d     = s_file_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ISSUE;
                    r_d          = r_in;
                    sigma_d      = sigma_in;
                    dt_d         = dt_in;
                    pending_d    = '0;
                    issue_path_d = '0;
                    issue_step_d = '0;
                    ret_path_d   = '0;
                    ret_step_d   = '0;
                    for (int p = 0; p < NUM_PATHS; p++) begin
                        s_file_d[p] = S0;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue_fire && issue_is_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (res_fire && ret_is_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The returning path is always pending and the issuing path never is, so the
        // two updates below never touch the same pending bit.
        if (res_fire) begin
            s_file_d[ret_path_q]  = res_S;
            pending_d[ret_path_q] = 1'b0;
            if (ret_path_q == LAST_PATH) begin
                ret_path_d = '0;
                ret_step_d = ret_step_q + 1'b1;
            end else begin
                ret_path_d = ret_path_q + 1'b1;
            end
        end

        if (issue_fire) begin
            pending_d[issue_path_q] = 1'b1;
            if (issue_path_q == LAST_PATH) begin
                issue_path_d = '0;
                issue_step_d = issue_step_q + 1'b1;
            end else begin
                issue_path_d = issue_path_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issue_path_q <= '0;
            issue_step_q <= '0;
            ret_path_q   <= '0;
            ret_step_q   <= '0;
            pending_q    <= '0;
            r_q          <= '0;
            sigma_q      <= '0;
            dt_q         <= '0;
            s_file_q     <= '{default: '0};
        end else begin
            state_q      <= state_d;
            issue_path_q <= issue_path_d;
            issue_step_q <= issue_step_d;
            ret_path_q   <= ret_path_d;
            ret_step_q   <= ret_step_d;
            pending_q    <= pending_d;
            r_q          <= r_d;
            sigma_q      <= sigma_d;
            dt_q         <= dt_d;
            s_file_q     <= s_file_d;
        end
    end

endmodule

// File: tb/tb_gbm_path_sequencer.sv
// Self-checking bench: a table of batch scenarios plus hand-written corner sequences,
// checked every cycle against a transaction-count model of the issue/return rules.
module tb_gbm_path_sequencer;

    localparam int WIDTH = 32;
    localparam int NP    = 4;
    localparam int NS    = 3;
    localparam int TOTAL = NP * NS;
    localparam int PW    = 2;
    localparam int SW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] S0, r_in, sigma_in, dt_in;
    logic             busy, done;
    logic             z_valid, z_ready;
    logic [WIDTH-1:0] z;
    logic             gbm_valid, gbm_ready;
    logic [WIDTH-1:0] gbm_z, gbm_S, gbm_r, gbm_sigma, gbm_dt;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_S;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_S;
    logic [PW-1:0]    out_path;
    logic [SW-1:0]    out_step;
    logic             out_last;

    always #5 clk = ~clk;

    gbm_path_sequencer #(
        .WIDTH(WIDTH), .QFRAC(16), .NUM_PATHS(NP), .NUM_STEPS(NS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .S0(S0), .r_in(r_in), .sigma_in(sigma_in), .dt_in(dt_in),
        .busy(busy), .done(done),
        .z_valid(z_valid), .z_ready(z_ready), .z(z),
        .gbm_valid(gbm_valid), .gbm_ready(gbm_ready),
        .gbm_z(gbm_z), .gbm_S(gbm_S), .gbm_r(gbm_r), .gbm_sigma(gbm_sigma), .gbm_dt(gbm_dt),
        .res_valid(res_valid), .res_ready(res_ready), .res_S(res_S),
        .out_valid(out_valid), .out_ready(out_ready), .out_S(out_S),
        .out_path(out_path), .out_step(out_step), .out_last(out_last)
    );

    typedef struct {
        logic [31:0] s0;
        logic [31:0] delta;
        int          lat;
        int          zv_pct;
        int          gr_pct;
        int          or_pct;
        logic [31:0] exp_final;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        int          due;
    } lane_t;

    lane_t       lane_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cfg_r, cfg_sigma, cfg_dt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_gbm_valid"}, 32'(gbm_valid), 32'd0);
        chk({tag, "_z_ready"}, 32'(z_ready), 32'd0);
        chk({tag, "_res_ready"}, 32'(res_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Drives one batch; the GBM lane model adds v.delta with latency v.lat.
    // Windows: out_ready forced low 20 cycles, z_valid forced low 5 cycles, stray start.
    task automatic run_batch(input vec_t v, input int or_stall_at, input int zv_off_at,
                             input int start_at, input int abort_after);
        int          issued = 0;
        int          outs   = 0;
        int          post   = 0;
        int          t      = 0;
        bit          fin    = 0;
        bit          after, pend, can_issue, has_out;
        logic [31:0] exp_s;
        cfg_r     = $urandom;
        cfg_sigma = $urandom;
        cfg_dt    = $urandom;
        @(posedge clk); #1;
        S0 = v.s0; r_in = cfg_r; sigma_in = cfg_sigma; dt_in = cfg_dt;
        start = 1'b1; z_valid = 1'b1; gbm_ready = 1'b1; out_ready = 1'b1;
        res_valid = 1'b1; res_S = $urandom; z = $urandom;
        @(negedge clk);
        check_quiet("idle");
        while (!fin && t < 3000) begin
            @(posedge clk); #1;
            start = (t == start_at);
            if (start) begin
                S0 = ~v.s0; r_in = ~cfg_r; sigma_in = ~cfg_sigma; dt_in = ~cfg_dt;
            end
            z_valid   = (t >= zv_off_at && t < zv_off_at + 5) ? 1'b0 : roll(v.zv_pct);
            z         = $urandom;
            gbm_ready = roll(v.gr_pct);
            out_ready = (t >= or_stall_at && t < or_stall_at + 20) ? 1'b0 : roll(v.or_pct);
            if (lane_q.size() > 0) begin
                res_valid = (lane_q[0].due <= t);
                res_S     = lane_q[0].s;
            end else begin
                res_valid = ($urandom_range(3) == 0);
                res_S     = $urandom;
            end
            @(negedge clk);
            after     = (outs == TOTAL);
            pend      = (issued >= NP) && (outs <= issued - NP);
            can_issue = (issued < TOTAL) && !pend;
            has_out   = (issued > outs);
            chk("gbm_valid", 32'(gbm_valid), 32'(can_issue && z_valid));
            chk("z_ready", 32'(z_ready), 32'(can_issue && gbm_ready));
            chk("res_ready", 32'(res_ready), 32'(has_out && out_ready));
            chk("out_valid", 32'(out_valid), 32'(has_out && res_valid));
            chk("busy", 32'(busy), 32'(outs < TOTAL));
            chk("done", 32'(done), 32'(after && post == 0));
            if (gbm_valid && gbm_ready && issued < TOTAL) begin
                exp_s = v.s0 + 32'(issued / NP) * v.delta;
                chk("gbm_S", gbm_S, exp_s);
                chk("gbm_z", gbm_z, z);
                chk("gbm_r", gbm_r, cfg_r);
                chk("gbm_sigma", gbm_sigma, cfg_sigma);
                chk("gbm_dt", gbm_dt, cfg_dt);
                lane_q.push_back('{s: gbm_S + v.delta, due: t + v.lat});
                issued++;
            end
            if (out_valid && out_ready && outs < TOTAL) begin
                exp_s = v.s0 + 32'(outs / NP + 1) * v.delta;
                chk("out_S", out_S, exp_s);
                chk("out_path", 32'(out_path), 32'(outs % NP));
                chk("out_step", 32'(out_step), 32'(outs / NP));
                chk("out_last", 32'(out_last), 32'(outs == TOTAL - 1));
                $display("out #%0d path=%0d step=%0d S=%h last=%b", outs, out_path, out_step,
                         out_S, out_last);
                outs++;
            end
            if (res_valid && res_ready && lane_q.size() > 0) begin
                lane_q.delete(0);
            end
            if (after) begin
                if (post == 1) begin
                    chk("final_S", gbm_S, v.exp_final);
                    fin = 1;
                end
                post++;
            end
            if (abort_after > 0 && issued >= abort_after) begin
                return;
            end
            t++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: batch ended with %0d outputs, required %0d", outs, TOTAL);
        end
    endtask

    initial begin
        vec_t vecs[6];
        rst_n = 1'b0; start = 1'b0;
        S0 = '0; r_in = '0; sigma_in = '0; dt_in = '0;
        z_valid = 1'b1; z = '0; gbm_ready = 1'b1;
        res_valid = 1'b1; res_S = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        chk("reset_gbm_S", gbm_S, 32'd0);
        rst_n = 1'b1;

        vecs[0] = '{32'h0064_0000, 32'h0,         3,  100, 100, 100, 32'h0064_0000};
        vecs[1] = '{32'h0064_0000, 32'h0001_0000, 2,  100, 100, 100, 32'h0067_0000};
        vecs[2] = '{32'h0064_0000, 32'h0001_0000, 10, 100, 100, 100, 32'h0067_0000};
        for (int i = 3; i < 6; i++) begin
            vecs[i].s0     = $urandom;
            vecs[i].delta  = $urandom_range(32'h0004_0000);
            vecs[i].lat    = int'($urandom_range(1, 9));
            vecs[i].zv_pct = 70;
            vecs[i].gr_pct = 60;
            vecs[i].or_pct = 60;
            vecs[i].exp_final = vecs[i].s0 + 32'(NS) * vecs[i].delta;
        end

        for (int i = 0; i < 6; i++) begin
            run_batch(vecs[i], -100, -100, -1, 0);
        end

        // Downstream stall mid-batch.
        run_batch(vecs[1], 6, -100, -1, 0);
        // z stream gap plus a start pulse while busy.
        run_batch(vecs[2], -100, 3, 4, 0);

        // Asynchronous reset after five issues, then a clean batch.
        run_batch(vecs[1], -100, -100, -1, 5);
        #2 rst_n = 1'b0;
        #1 check_quiet("midreset");
        lane_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_batch(vecs[3], -100, -100, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
